cache_mem_arbiter: RTL and testbench

//  Shares the single memory port between two cache controllers (0 = I-cache, 1 = D-cache).

---
 rtl/cache_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache (0) and D-cache (1).
// One transaction in flight; blocks are serialized into BUS_W beats and returned whole.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BLOCK_W = 256,
  parameter int unsigned BUS_W   = 32
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [1:0]           req_valid_in,
  output logic [1:0]           req_ready_out,
  input  logic [1:0]           req_we_in,
  input  logic [2*ADDR_W-1:0]  req_addr_in,
  input  logic [2*BLOCK_W-1:0] req_wdata_in,
  output logic [1:0]           resp_valid_out,
  output logic [BLOCK_W-1:0]   resp_data_out,
  output logic                 mem_cmd_valid_out,
  input  logic                 mem_cmd_ready_in,
  output logic                 mem_cmd_we_out,
  output logic [ADDR_W-1:0]    mem_cmd_addr_out,
  output logic                 mem_wdata_valid_out,
  input  logic                 mem_wdata_ready_in,
  output logic [BUS_W-1:0]     mem_wdata_out,
  input  logic                 mem_rdata_valid_in,
  input  logic [BUS_W-1:0]     mem_rdata_in,
  input  logic                 mem_wack_in
);

  localparam int unsigned BEATS  = BLOCK_W / BUS_W;
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(BLOCK_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_WACK  = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BLOCK_W-1:0]  blk_q, blk_d;
  logic                gnt_sel;
  logic [ADDR_W-1:0]   sel_addr;

  // Round-robin pick: favour rr_q, fall back to the other requester.
  always_comb begin
    gnt_sel  = req_valid_in[rr_q] ? rr_q : ~rr_q;
    sel_addr = gnt_sel ? req_addr_in[ADDR_W +: ADDR_W] : req_addr_in[0 +: ADDR_W];
  end

  // Next-state and datapath update; blk_q doubles as writeback source and refill sink.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid_in) begin
          gnt_d   = gnt_sel;
          we_d    = req_we_in[gnt_sel];
          addr_d  = {sel_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          blk_d   = gnt_sel ? req_wdata_in[BLOCK_W +: BLOCK_W] : req_wdata_in[0 +: BLOCK_W];
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_cmd_ready_in) begin
          beat_d  = '0;
          state_d = we_q ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        if (mem_wdata_ready_in) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_WACK;
        end
      end
      S_WACK: begin
        if (mem_wack_in) state_d = S_RESP;
      end
      S_RDATA: begin
        if (mem_rdata_valid_in) begin
          blk_d[int'(beat_q)*BUS_W +: BUS_W] = mem_rdata_in;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_RESP;
        end
      end
      S_RESP: begin
        rr_d    = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
    end
  end

  // Grant is combinational and masked while reset is held.
  assign req_ready_out = (reset_in && state_q == S_IDLE && |req_valid_in) ?
                         (gnt_sel ? 2'b10 : 2'b01) : 2'b00;

  assign resp_valid_out      = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data_out       = blk_q;
  assign mem_cmd_valid_out   = (state_q == S_CMD);
  assign mem_cmd_we_out      = we_q;
  assign mem_cmd_addr_out    = addr_q;
  assign mem_wdata_valid_out = (state_q == S_WDATA);
  assign mem_wdata_out       = blk_q[int'(beat_q)*BUS_W +: BUS_W];

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level model plus directed scenarios with literal pins.
module tb_cache_mem_arbiter;

  localparam int BEATS = 8;

  logic         clk_in, reset_in;
  logic [1:0]   req_valid_in, req_ready_out, req_we_in, resp_valid_out;
  logic [63:0]  req_addr_in;
  logic [511:0] req_wdata_in;
  logic [255:0] resp_data_out;
  logic         mem_cmd_valid_out, mem_cmd_ready_in, mem_cmd_we_out;
  logic [31:0]  mem_cmd_addr_out, mem_wdata_out, mem_rdata_in;
  logic         mem_wdata_valid_out, mem_wdata_ready_in, mem_rdata_valid_in, mem_wack_in;

  cache_mem_arbiter dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_we_in(req_we_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .mem_cmd_valid_out(mem_cmd_valid_out), .mem_cmd_ready_in(mem_cmd_ready_in),
    .mem_cmd_we_out(mem_cmd_we_out), .mem_cmd_addr_out(mem_cmd_addr_out),
    .mem_wdata_valid_out(mem_wdata_valid_out), .mem_wdata_ready_in(mem_wdata_ready_in),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_valid_in(mem_rdata_valid_in),
    .mem_rdata_in(mem_rdata_in), .mem_wack_in(mem_wack_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Requesters: a request stays pending until the model sees it granted.
  logic [1:0]   pend;
  logic         pend_we [2];
  logic [31:0]  pend_addr [2];
  logic [255:0] pend_wdata [2];

  // Transaction-level model of the arbiter.
  int           busy, rr, g, cmd_done, beats, wack_cnt, resp_due;
  logic         t_we;
  logic [31:0]  t_addr;
  logic [255:0] t_wdata, rd_blk;

  // Memory behaviour knobs.
  int           cmd_stall, wr_toggle, wr_phase, wack_dly, stray_rd;
  logic [31:0]  rd_base;

  // Observations of the DUT used by the literal checks.
  bit           grant_log[$];
  logic [31:0]  wlog[$];
  int           grant_cyc, resp_cyc, wack_cyc, resp_cnt, cmd_hi;
  logic [1:0]   resp_last;
  logic [255:0] resp_dat;
  logic [31:0]  cmd_addr_seen;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    busy = 0; rr = 0; g = 0; cmd_done = 0; beats = 0; wack_cnt = 0; resp_due = 0;
    pend = 2'b00; cmd_stall = 0; wr_toggle = 0; wr_phase = 1; wack_dly = 2; stray_rd = 0;
  endtask

  task automatic cycle();
    int gsel;
    logic rd_now, wack_now, exp_wv;
    logic [1:0] exp_ready;
    @(posedge clk_in);
    #1;
    cyc++;
    req_valid_in = pend;
    for (int n = 0; n < 2; n++) begin
      req_we_in[n]               = pend_we[n];
      req_addr_in[n*32 +: 32]    = pend_addr[n];
      req_wdata_in[n*256 +: 256] = pend_wdata[n];
    end
    rd_now             = (busy != 0) && (cmd_done != 0) && !t_we && beats < BEATS;
    wack_now           = (busy != 0) && t_we && beats == BEATS && resp_due == 0 && wack_cnt == wack_dly;
    mem_cmd_ready_in   = (cmd_stall == 0);
    mem_rdata_valid_in = rd_now || (stray_rd != 0 && busy == 0);
    mem_rdata_in       = rd_now ? rd_base + 32'(beats) : 32'hDEAD_BEEF;
    mem_wdata_ready_in = (wr_toggle != 0) ? wr_phase[0] : 1'b1;
    mem_wack_in        = wack_now;
    #1;
    gsel      = pend[rr] ? rr : 1 - rr;
    exp_ready = (busy == 0 && pend != 0) ? (2'b01 << gsel) : 2'b00;
    exp_wv    = (busy != 0) && t_we && (cmd_done != 0) && beats < BEATS;
    chk("req_ready", req_ready_out, exp_ready);
    chk("cmd_valid", mem_cmd_valid_out, (busy != 0 && cmd_done == 0));
    if (busy != 0 && cmd_done == 0) begin
      chk("cmd_addr", mem_cmd_addr_out, {t_addr[31:5], 5'b0});
      chk("cmd_we", mem_cmd_we_out, t_we);
    end
    chk("wdata_valid", mem_wdata_valid_out, exp_wv);
    if (exp_wv) chk("wdata_beat", mem_wdata_out, t_wdata[beats*32 +: 32]);
    chk("resp_valid", resp_valid_out, (resp_due != 0) ? (2'b01 << g) : 2'b00);
    if (resp_due != 0 && !t_we) chk("resp_data", resp_data_out, rd_blk);
    if (req_ready_out != 2'b00) begin grant_log.push_back(req_ready_out[1]); grant_cyc = cyc; end
    if (resp_valid_out != 2'b00) begin
      resp_cyc = cyc; resp_cnt++; resp_last = resp_valid_out; resp_dat = resp_data_out;
    end
    if (mem_cmd_valid_out) begin cmd_hi++; cmd_addr_seen = mem_cmd_addr_out; end
    if (mem_wdata_valid_out && mem_wdata_ready_in) wlog.push_back(mem_wdata_out);
    if (wack_now) wack_cyc = cyc;
    // Advance the model across the coming edge.
    if (wr_toggle != 0) wr_phase = 1 - wr_phase;
    if (resp_due != 0) begin
      busy = 0; resp_due = 0; rr = 1 - g;
    end else if (busy == 0) begin
      if (pend != 0) begin
        g = gsel; busy = 1; t_we = pend_we[g]; t_addr = pend_addr[g]; t_wdata = pend_wdata[g];
        pend[g] = 1'b0; cmd_done = 0; beats = 0; wack_cnt = 0; rd_blk = '0;
      end
    end else if (cmd_done == 0) begin
      if (mem_cmd_ready_in) cmd_done = 1;
      else if (cmd_stall > 0) cmd_stall--;
    end else if (!t_we) begin
      rd_blk[beats*32 +: 32] = mem_rdata_in;
      beats++;
      if (beats == BEATS) resp_due = 1;
    end else if (beats < BEATS) begin
      if (mem_wdata_ready_in) beats++;
    end else begin
      if (wack_now) resp_due = 1;
      else wack_cnt++;
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while ((busy != 0 || pend != 0) && n < budget) begin cycle(); n++; end
    chk({name, "_timeout"}, (busy != 0 || pend != 0), 1'b0);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once even with both requests raised.
  task automatic do_reset(input string tag);
    @(posedge clk_in);
    #3;
    reset_in = 1'b0;
    req_valid_in = 2'b11; mem_cmd_ready_in = 1'b0; mem_wdata_ready_in = 1'b0;
    mem_rdata_valid_in = 1'b0; mem_wack_in = 1'b0;
    #1;
    chk({tag, "_req_ready"}, req_ready_out, 2'b00);
    chk({tag, "_resp_valid"}, resp_valid_out, 2'b00);
    chk({tag, "_resp_data"}, resp_data_out, '0);
    chk({tag, "_cmd_valid"}, mem_cmd_valid_out, 1'b0);
    chk({tag, "_cmd_we"}, mem_cmd_we_out, 1'b0);
    chk({tag, "_cmd_addr"}, mem_cmd_addr_out, 32'h0);
    chk({tag, "_wdata_valid"}, mem_wdata_valid_out, 1'b0);
    chk({tag, "_wdata"}, mem_wdata_out, 32'h0);
    model_clear();
    req_valid_in = 2'b00;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
  endtask

  task automatic set_req(input int n, input logic we, input logic [31:0] addr, input logic [255:0] wd);
    pend[n] = 1'b1; pend_we[n] = we; pend_addr[n] = addr; pend_wdata[n] = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] wd;
    int n;
    reset_in = 1'b1; req_valid_in = '0; req_we_in = '0; req_addr_in = '0; req_wdata_in = '0;
    mem_cmd_ready_in = 0; mem_wdata_ready_in = 0; mem_rdata_valid_in = 0; mem_rdata_in = '0;
    mem_wack_in = 0;
    for (int i = 0; i < 2; i++) begin pend_we[i] = 0; pend_addr[i] = '0; pend_wdata[i] = '0; end
    model_clear();
    resp_cnt = 0; cmd_hi = 0;
    do_reset("reset");

    // T1: refill latency and data.
    rd_base = 32'hA000_0000;
    set_req(0, 1'b0, 32'h0000_0040, '0);
    run_until_idle("t1", 40);
    chk("t1_latency", 32'(resp_cyc - grant_cyc), 32'd10);
    chk("t1_resp_onehot", resp_last, 2'b01);
    chk("t1_data_lo", resp_dat[31:0], 32'hA000_0000);
    chk("t1_data_hi", resp_dat[255:224], 32'hA000_0007);

    // T2: contention after reset alternates 0,1,0,1.
    do_reset("t2_reset");
    grant_log.delete();
    set_req(0, 1'b0, 32'h0000_1000, '0);
    set_req(1, 1'b0, 32'h0000_2000, '0);
    run_until_idle("t2a", 60);
    set_req(0, 1'b0, 32'h0000_3000, '0);
    set_req(1, 1'b0, 32'h0000_4000, '0);
    run_until_idle("t2b", 60);
    chk("t2_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("t2_g0", grant_log[0], 1'b0);
      chk("t2_g1", grant_log[1], 1'b1);
      chk("t2_g2", grant_log[2], 1'b0);
      chk("t2_g3", grant_log[3], 1'b1);
    end

    // T3: writeback with a toggling beat ready and delayed ack.
    for (int k = 0; k < BEATS; k++) wd[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    wlog.delete();
    wr_toggle = 1; wr_phase = 1; wack_dly = 2;
    set_req(1, 1'b1, 32'h0000_0800, wd);
    run_until_idle("t3", 60);
    wr_toggle = 0;
    chk("t3_beats", 32'(wlog.size()), 32'd8);
    for (int k = 0; k < BEATS && k < wlog.size(); k++) chk("t3_beat", wlog[k], 32'hB000_0000 + 32'(k));
    chk("t3_resp_after_wack", 32'(resp_cyc - wack_cyc), 32'd1);
    chk("t3_resp_onehot", resp_last, 2'b10);

    // T4: command stalled for five cycles.
    cmd_hi = 0; cmd_stall = 5;
    set_req(0, 1'b0, 32'h0000_0080, '0);
    run_until_idle("t4", 60);
    chk("t4_cmd_cycles", 32'(cmd_hi), 32'd6);

    // T5: reset in the middle of a refill, then contention proves rr restarts at 0.
    set_req(0, 1'b0, 32'h0000_00C0, '0);
    n = 0;
    while (!(busy != 0 && cmd_done != 0 && beats == 4) && n < 30) begin cycle(); n++; end
    chk("t5_reach_beat3", (busy != 0 && cmd_done != 0 && beats == 4), 1'b1);
    do_reset("t5_reset");
    grant_log.delete();
    rd_base = 32'hC000_0000;
    set_req(0, 1'b0, 32'h0000_0100, '0);
    set_req(1, 1'b0, 32'h0000_0200, '0);
    run_until_idle("t5", 60);
    chk("t5_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("t5_g0", grant_log[0], 1'b0);
      chk("t5_g1", grant_log[1], 1'b1);
    end
    chk("t5_resp_onehot", resp_last, 2'b10);
    chk("t5_data_lo", resp_dat[31:0], 32'hC000_0000);
    chk("t5_data_hi", resp_dat[255:224], 32'hC000_0007);

    // T6: unaligned address and stray read beats while idle.
    set_req(0, 1'b0, 32'h1000_0014, '0);
    run_until_idle("t6", 40);
    chk("t6_cmd_addr", cmd_addr_seen, 32'h1000_0000);
    n = resp_cnt;
    stray_rd = 1;
    repeat (5) cycle();
    stray_rd = 0;
    chk("t6_stray_resp", 32'(resp_cnt), 32'(n));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
